// File: rtl/execution_md_pkg.sv
// rtl/execution_md_pkg.sv - shared RV32I/RV32M operation encodings and EX-stage constants
package riscv_definitions;

    localparam int REG_ADDR = 5;
    localparam int ALU_OP_W = 4;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
        ALU_OR, ALU_AND, ALU_EQ, ALU_NE, ALU_LT, ALU_GE, ALU_LTU, ALU_GEU
    } aluOpType;

    typedef enum logic [2:0] {
        MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_DIV, MD_DIVU, MD_REM, MD_REMU
    } mdOpType;

    typedef enum logic [1:0] {DIV_IDLE, DIV_RUN, DIV_DONE} divStateType;

endpackage

// File: rtl/execution_md_divider.sv
// rtl/execution_md_divider.sv - iterative restoring radix-2 divider with div-by-zero/overflow shortcuts
module divider_radix2
    import riscv_definitions::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clk_en,
    input  logic            start_i,
    input  logic            signed_i,
    input  logic            rem_sel_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    divStateType     state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0] quo_q, rem_q, dvs_q;
    logic            neg_quo_q, neg_rem_q, rem_sel_q, special_q;

    logic            a_neg, b_neg, ovf;
    logic [XLEN-1:0] a_abs, b_abs, quo_fix, rem_fix;
    logic [XLEN:0]   shifted, diff;

    always_comb begin
        a_neg   = signed_i & a_i[XLEN-1];
        b_neg   = signed_i & b_i[XLEN-1];
        a_abs   = a_neg ? -a_i : a_i;
        b_abs   = b_neg ? -b_i : b_i;
        ovf     = signed_i & (a_i == MIN_VAL) & (b_i == {XLEN{1'b1}});
        shifted = {rem_q, quo_q[XLEN-1]};
        diff    = shifted - {1'b0, dvs_q};
        // Shortcut results are already final and must bypass sign correction.
        quo_fix = (!special_q && neg_quo_q) ? -quo_q : quo_q;
        rem_fix = (!special_q && neg_rem_q) ? -rem_q : rem_q;
        result_o = rem_sel_q ? rem_fix : quo_fix;
        busy_o  = (state_q == DIV_RUN) | ((state_q == DIV_IDLE) & start_i);
        done_o  = (state_q == DIV_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= DIV_IDLE;
            cnt_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            rem_sel_q <= 1'b0;
            special_q <= 1'b0;
        end else if (clk_en) begin
            case (state_q)
                DIV_IDLE: begin
                    if (start_i) begin
                        rem_sel_q <= rem_sel_i;
                        neg_quo_q <= a_neg ^ b_neg;
                        neg_rem_q <= a_neg;
                        cnt_q     <= CNT_W'(XLEN);
                        dvs_q     <= b_abs;
                        if (b_i == '0) begin
                            quo_q     <= {XLEN{1'b1}};
                            rem_q     <= a_i;
                            special_q <= 1'b1;
                            state_q   <= DIV_DONE;
                        end else if (ovf) begin
                            quo_q     <= MIN_VAL;
                            rem_q     <= '0;
                            special_q <= 1'b1;
                            state_q   <= DIV_DONE;
                        end else begin
                            quo_q     <= a_abs;
                            rem_q     <= '0;
                            special_q <= 1'b0;
                            state_q   <= DIV_RUN;
                        end
                    end
                end
                DIV_RUN: begin
                    if (!diff[XLEN]) begin
                        rem_q <= diff[XLEN-1:0];
                        quo_q <= {quo_q[XLEN-2:0], 1'b1};
                    end else begin
                        rem_q <= shifted[XLEN-1:0];
                        quo_q <= {quo_q[XLEN-2:0], 1'b0};
                    end
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) state_q <= DIV_DONE;
                end
                DIV_DONE: state_q <= DIV_IDLE;
                default:  state_q <= DIV_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/execution_md.sv
// rtl/execution_md.sv - RV32IM EX stage: ALU, multiplier, branch resolution, divider stall and EX register
module execution_md
    import riscv_definitions::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clk_en,
    input  logic                i_id_alu_src1,
    input  logic                i_id_alu_src2,
    input  logic [ALU_OP_W-1:0] i_id_alu_op,
    input  logic                i_id_md_en,
    input  logic                i_id_branch,
    input  logic                i_id_jump,
    input  logic [XLEN-1:0]     i_id_pc,
    input  logic [XLEN-1:0]     i_id_imm,
    input  logic [XLEN-1:0]     i_id_reg_read_data1,
    input  logic [XLEN-1:0]     i_id_reg_read_data2,
    input  logic                i_id_mem_to_reg,
    input  logic                i_id_reg_wr,
    input  logic                i_id_mem_rd,
    input  logic                i_id_mem_wr,
    input  logic                i_id_result_src,
    input  logic [REG_ADDR-1:0] i_id_reg_destination,
    input  logic [2:0]          i_id_funct3,
    input  logic [6:0]          i_id_funct7,
    output logic                o_ex_stall,
    output logic                o_ex_flush,
    output logic [XLEN-1:0]     o_ex_jump_addr,
    output logic [XLEN-1:0]     o_ex_alu_result,
    output logic [XLEN-1:0]     o_ex_pc_plus_4,
    output logic [XLEN-1:0]     o_ex_data2,
    output logic                o_ex_mem_to_reg,
    output logic                o_ex_reg_wr,
    output logic                o_ex_mem_rd,
    output logic                o_ex_mem_wr,
    output logic                o_ex_result_src,
    output logic [REG_ADDR-1:0] o_ex_reg_destination,
    output logic [2:0]          o_ex_funct3,
    output logic [6:0]          o_ex_funct7
);

    localparam int SHW = $clog2(XLEN);
    localparam int W2  = 2 * XLEN;

    logic [XLEN-1:0] op_a, op_b, alu_out, mul_result, div_result, ex_result;
    logic [W2-1:0]   mul_a, mul_b, prod;
    logic [SHW-1:0]  shamt;
    logic            a_sgn, b_sgn, taken, div_start, div_busy, div_done;

    always_comb begin
        op_a  = i_id_alu_src1 ? i_id_pc  : i_id_reg_read_data1;
        op_b  = i_id_alu_src2 ? i_id_imm : i_id_reg_read_data2;
        shamt = op_b[SHW-1:0];
        alu_out = '0;
        case (aluOpType'(i_id_alu_op))
            ALU_ADD:  alu_out = op_a + op_b;
            ALU_SUB:  alu_out = op_a - op_b;
            ALU_SLL:  alu_out = op_a << shamt;
            ALU_SLT:  alu_out = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            ALU_SLTU: alu_out = {{(XLEN-1){1'b0}}, op_a < op_b};
            ALU_XOR:  alu_out = op_a ^ op_b;
            ALU_SRL:  alu_out = op_a >> shamt;
            ALU_SRA:  alu_out = XLEN'($signed(op_a) >>> shamt);
            ALU_OR:   alu_out = op_a | op_b;
            ALU_AND:  alu_out = op_a & op_b;
            ALU_EQ:   alu_out = {{(XLEN-1){1'b0}}, op_a == op_b};
            ALU_NE:   alu_out = {{(XLEN-1){1'b0}}, op_a != op_b};
            ALU_LT:   alu_out = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            ALU_GE:   alu_out = {{(XLEN-1){1'b0}}, $signed(op_a) >= $signed(op_b)};
            ALU_LTU:  alu_out = {{(XLEN-1){1'b0}}, op_a < op_b};
            ALU_GEU:  alu_out = {{(XLEN-1){1'b0}}, op_a >= op_b};
            default:  alu_out = '0;
        endcase

        // MULH treats both operands as signed, MULHSU only rs1, MULHU neither.
        a_sgn = (i_id_funct3[1:0] == 2'd1) | (i_id_funct3[1:0] == 2'd2);
        b_sgn = (i_id_funct3[1:0] == 2'd1);
        mul_a = {{XLEN{a_sgn & op_a[XLEN-1]}}, op_a};
        mul_b = {{XLEN{b_sgn & op_b[XLEN-1]}}, op_b};
        prod  = mul_a * mul_b;
        mul_result = (i_id_funct3[1:0] == 2'd0) ? prod[XLEN-1:0] : prod[W2-1:XLEN];

        div_start = i_id_md_en & i_id_funct3[2];
        ex_result = !i_id_md_en ? alu_out : (div_done ? div_result : mul_result);
        taken     = i_id_jump | (i_id_branch & alu_out[0]);
        o_ex_stall = rst_n & div_busy;
    end

    divider_radix2 #(.XLEN(XLEN), .CNT_W(CNT_W)) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .clk_en    (clk_en),
        .start_i   (div_start),
        .signed_i  (~i_id_funct3[0]),
        .rem_sel_i (i_id_funct3[1]),
        .a_i       (op_a),
        .b_i       (op_b),
        .busy_o    (div_busy),
        .done_o    (div_done),
        .result_o  (div_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_ex_flush           <= 1'b0;
            o_ex_jump_addr       <= '0;
            o_ex_alu_result      <= '0;
            o_ex_pc_plus_4       <= '0;
            o_ex_data2           <= '0;
            o_ex_mem_to_reg      <= 1'b0;
            o_ex_reg_wr          <= 1'b0;
            o_ex_mem_rd          <= 1'b0;
            o_ex_mem_wr          <= 1'b0;
            o_ex_result_src      <= 1'b0;
            o_ex_reg_destination <= '0;
            o_ex_funct3          <= '0;
            o_ex_funct7          <= '0;
        end else if (clk_en) begin
            if (div_busy) begin
                // Bubble: kill side effects, leave the data fields as they were.
                o_ex_flush  <= 1'b0;
                o_ex_reg_wr <= 1'b0;
                o_ex_mem_rd <= 1'b0;
                o_ex_mem_wr <= 1'b0;
            end else begin
                o_ex_flush           <= taken;
                o_ex_jump_addr       <= (i_id_branch & taken) ? i_id_pc + i_id_imm : alu_out;
                o_ex_alu_result      <= ex_result;
                o_ex_pc_plus_4       <= i_id_pc + XLEN'(4);
                o_ex_data2           <= i_id_reg_read_data2;
                o_ex_mem_to_reg      <= i_id_mem_to_reg;
                o_ex_reg_wr          <= i_id_reg_wr;
                o_ex_mem_rd          <= i_id_mem_rd;
                o_ex_mem_wr          <= i_id_mem_wr;
                o_ex_result_src      <= i_id_result_src;
                o_ex_reg_destination <= i_id_reg_destination;
                o_ex_funct3          <= i_id_funct3;
                o_ex_funct7          <= i_id_funct7;
            end
        end
    end

endmodule
